// File: rtl/decode_issue_stage.sv
// Registered multi-lane RV32I decode stage. Bundles whose later lanes read a
// register written by an earlier lane are issued over several beats.
`ifndef CTRL_BUS
`define CTRL_BUS 11
`endif
`ifndef REGWRITE
`define REGWRITE 0
`endif

module decode_issue_stage #(
  parameter int LANES        = 2,
  parameter int XLEN         = 32,
  parameter int CTRL_W       = `CTRL_BUS,
  parameter int REGWRITE_BIT = `REGWRITE,
  parameter bit HAZARD_SPLIT = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*32-1:0]     in_inst_i,
  input  logic [LANES*XLEN-1:0]   in_pc_i,
  input  logic [LANES-1:0]        in_fetched_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*CTRL_W-1:0] out_ctrl_o,
  output logic [LANES*32-1:0]     out_inst_o,
  output logic [LANES*XLEN-1:0]   out_pc_o,
  output logic [LANES-1:0]        out_lane_valid_o,
  output logic [LANES-1:0]        out_illegal_o,
  output logic [LANES-1:0]        out_misalign_o
);

  localparam int C_ALUI    = 1;
  localparam int C_ALUR    = 2;
  localparam int C_LOAD    = 3;
  localparam int C_STORE   = 4;
  localparam int C_BRANCH  = 5;
  localparam int C_JAL     = 6;
  localparam int C_JALR    = 7;
  localparam int C_UPPER   = 8;
  localparam int C_MISC    = 9;
  localparam int C_ILLEGAL = 10;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SPLIT = 1'b1;

  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [31:0] inst);
    logic [CTRL_W-1:0] c;
    logic [2:0]        f3;
    logic [6:0]        f7;
    c  = '0;
    f3 = inst[14:12];
    f7 = inst[31:25];
    case (inst[6:0])
      7'b0110111, 7'b0010111: begin c[C_UPPER] = 1'b1; c[REGWRITE_BIT] = 1'b1; end
      7'b1101111: begin c[C_JAL] = 1'b1; c[REGWRITE_BIT] = 1'b1; end
      7'b1100111:
        if (f3 == 3'b000) begin c[C_JALR] = 1'b1; c[REGWRITE_BIT] = 1'b1; end
        else c[C_ILLEGAL] = 1'b1;
      7'b1100011:
        if (f3 != 3'b010 && f3 != 3'b011) c[C_BRANCH] = 1'b1;
        else c[C_ILLEGAL] = 1'b1;
      7'b0000011:
        if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
          c[C_LOAD] = 1'b1; c[REGWRITE_BIT] = 1'b1;
        end else c[C_ILLEGAL] = 1'b1;
      7'b0100011:
        if (f3 <= 3'b010) c[C_STORE] = 1'b1;
        else c[C_ILLEGAL] = 1'b1;
      7'b0010011:
        if ((f3 == 3'b001 && f7 != 7'd0) ||
            (f3 == 3'b101 && f7 != 7'd0 && f7 != 7'b0100000)) c[C_ILLEGAL] = 1'b1;
        else begin c[C_ALUI] = 1'b1; c[REGWRITE_BIT] = 1'b1; end
      7'b0110011:
        if (f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          c[C_ALUR] = 1'b1; c[REGWRITE_BIT] = 1'b1;
        end else c[C_ILLEGAL] = 1'b1;
      7'b0001111: c[C_MISC] = 1'b1;
      7'b1110011:
        if (f3 == 3'b000) begin
          if (inst[31:7] == 25'h0 || inst[31:7] == 25'h0002000) c[C_MISC] = 1'b1;
          else c[C_ILLEGAL] = 1'b1;
        end else if (f3 != 3'b100) begin
          c[C_MISC] = 1'b1; c[REGWRITE_BIT] = 1'b1;
        end else c[C_ILLEGAL] = 1'b1;
      default: c[C_ILLEGAL] = 1'b1;
    endcase
    // x0 writes are architectural no-ops, except links that still redirect
    if (c[REGWRITE_BIT] && inst[11:7] == 5'd0 && !c[C_JAL] && !c[C_JALR]) c = '0;
    return c;
  endfunction

  logic [0:0]        state_r;
  logic [LANES-1:0]  rem_r;
  logic [CTRL_W-1:0] b_ctrl [LANES];
  logic [LANES-1:0]  b_ill, b_mis;

  logic [CTRL_W-1:0] dec_ctrl [LANES];
  logic [LANES-1:0]  dec_ill, dec_mis;
  logic [CTRL_W-1:0] src_ctrl [LANES];
  logic [4:0]        src_rd [LANES];
  logic [4:0]        src_rs1 [LANES];
  logic [4:0]        src_rs2 [LANES];
  logic [LANES-1:0]  src_mask, src_ill, src_mis, dep, issue, rest;
  logic              found, in_split, accept, load_beat;

  assign in_split   = (state_r == S_SPLIT);
  assign in_ready_o = !flush_i && !in_split && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign load_beat  = accept || (in_split && out_ready_i);

  // Per-lane decode of the incoming bundle
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      dec_ctrl[l] = '0;
      dec_ill[l]  = 1'b0;
      dec_mis[l]  = 1'b0;
      if (!in_fetched_i[l]) begin
        dec_mis[l] = 1'b0;
      end else if (in_pc_i[l*XLEN +: 2] != 2'b00) begin
        dec_mis[l] = 1'b1;
      end else begin
        dec_ctrl[l] = decode_ctrl(in_inst_i[l*32 +: 32]);
        dec_ill[l]  = dec_ctrl[l][C_ILLEGAL];
      end
    end
  end

  // Select the lanes that issue next, from the new bundle or the held remainder
  always_comb begin
    src_mask = in_split ? rem_r : in_fetched_i;
    src_ill  = in_split ? b_ill : dec_ill;
    src_mis  = in_split ? b_mis : dec_mis;
    dep      = '0;
    issue    = '0;
    rest     = '0;
    found    = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      src_ctrl[k] = in_split ? b_ctrl[k] : dec_ctrl[k];
      src_rd[k]   = in_split ? out_inst_o[k*32+7 +: 5]  : in_inst_i[k*32+7 +: 5];
      src_rs1[k]  = in_split ? out_inst_o[k*32+15 +: 5] : in_inst_i[k*32+15 +: 5];
      src_rs2[k]  = in_split ? out_inst_o[k*32+20 +: 5] : in_inst_i[k*32+20 +: 5];
    end
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < LANES; j++) begin
        if (j < k && src_mask[j] && src_mask[k] && src_ctrl[j][REGWRITE_BIT] &&
            src_rd[j] != 5'd0 && (src_rd[j] == src_rs1[k] || src_rd[j] == src_rs2[k])) begin
          dep[k] = 1'b1;
        end else begin
          dep[k] = dep[k];
        end
      end
    end
    for (int k = 0; k < LANES; k++) begin
      if (dep[k]) found = 1'b1;
      else found = found;
      if (src_mask[k] && found && HAZARD_SPLIT) rest[k] = 1'b1;
      else if (src_mask[k]) issue[k] = 1'b1;
      else issue[k] = 1'b0;
    end
  end

  // Split FSM, held bundle and registered output beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r          <= S_IDLE;
      rem_r            <= '0;
      b_ill            <= '0;
      b_mis            <= '0;
      out_valid_o      <= 1'b0;
      out_ctrl_o       <= '0;
      out_inst_o       <= '0;
      out_pc_o         <= '0;
      out_lane_valid_o <= '0;
      out_illegal_o    <= '0;
      out_misalign_o   <= '0;
      for (int l = 0; l < LANES; l++) b_ctrl[l] <= '0;
    end else if (flush_i) begin
      state_r          <= S_IDLE;
      rem_r            <= '0;
      out_valid_o      <= 1'b0;
      out_ctrl_o       <= '0;
      out_lane_valid_o <= '0;
      out_illegal_o    <= '0;
      out_misalign_o   <= '0;
    end else if (load_beat) begin
      out_valid_o      <= 1'b1;
      out_lane_valid_o <= issue;
      out_illegal_o    <= issue & src_ill;
      out_misalign_o   <= issue & src_mis;
      rem_r            <= rest;
      state_r          <= (rest != '0) ? S_SPLIT : S_IDLE;
      for (int l = 0; l < LANES; l++)
        out_ctrl_o[l*CTRL_W +: CTRL_W] <= issue[l] ? src_ctrl[l] : '0;
      if (accept) begin
        b_ill      <= dec_ill;
        b_mis      <= dec_mis;
        out_inst_o <= in_inst_i;
        out_pc_o   <= in_pc_i;
        for (int l = 0; l < LANES; l++) b_ctrl[l] <= dec_ctrl[l];
      end
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
Registered, multi-lane instruction decode stage for the superscalar front end. It decodes a bundle of LANES fetched instructions into per-lane control vectors, flags illegal instructions and misaligned PCs, and holds the result in an output register behind a valid/ready handshake. When a later lane reads a register written by an earlier lane in the same bundle, it splits the bundle across beats. It sits between the fetch buffer and register read / issue.

Parameters:
LANES, 2, instruction slots per bundle (1..4)
XLEN, 32, PC width
CTRL_W, `CTRL_BUS width, width of one lane's control vector
REGWRITE_BIT, `REGWRITE, index of the register-write bit in the control vector
HAZARD_SPLIT, 1, 1 = split bundles on intra-bundle RAW; 0 = always issue the whole bundle in one beat

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  discard held and pending lanes (redirect)
in_valid_i  in  1  input bundle valid
in_ready_o  out  1  stage can accept a bundle this cycle
in_inst_i  in  LANES*32  instructions; lane 0 in the LSBs
in_pc_i  in  LANES*XLEN  per-lane PCs
in_fetched_i  in  LANES  per-lane fetched flag
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream accepts the beat
out_ctrl_o  out  LANES*CTRL_W  per-lane control vectors
out_inst_o  out  LANES*32  per-lane instruction pass-through
out_pc_o  out  LANES*XLEN  per-lane PC pass-through
out_lane_valid_o  out  LANES  lane issues in this beat
out_illegal_o  out  LANES  lane holds an illegal encoding
out_misalign_o  out  LANES  lane PC[1:0] != 0

Behaviour:
- Reset is asynchronous. All outputs and registers are 0 and the FSM is in IDLE.
- Per-lane decode is combinational and uses the existing RV32I decode:
  - Unrecognised encoding: ctrl = ILLEGAL control vector, illegal = 1.
  - Write to x0 other than JAL/JALR: ctrl = 0.
  - PC[1:0] != 0: ctrl = 0, misalign = 1, illegal = 0.
  - Lane not fetched: ctrl = 0, lane_valid = 0, no flags set.
- Latency is 1 cycle from the input handshake to out_valid_o.
- Handshake:
  - in_ready_o = !flush_i && state != SPLIT && (!out_valid_o || out_ready_i).
  - A beat is accepted on in_valid_i && in_ready_o.
  - The output holds stable while out_valid_o && !out_ready_i.
- Hazard: lane k depends on an earlier pending lane j when j's ctrl[REGWRITE_BIT] = 1, rd_j != 0, and rd_j equals rs1_k or rs2_k. Raw fields are compared, which is conservative.
- FSM states:
  - IDLE: output register empty or draining. On accept, compute remaining mask R = fetched lanes. Issue every lane of R below the first dependent lane s. If no lane depends, or HAZARD_SPLIT = 0, issue all of R and stay in IDLE. Otherwise store R' = lanes >= s, keep the decoded bundle, and go to SPLIT.
  - SPLIT: when out_ready_i is high, load the next beat from R'. Dependency is re-evaluated only among the remaining lanes. Return to IDLE when R' issues in full.
  - Lanes not issued in a beat show lane_valid = 0 and ctrl = 0. inst and pc still pass through.
- A beat where no lanes are valid (nothing fetched) is still presented with out_valid_o = 1. Downstream ignores it.
- Flush:
  - Highest priority.
  - Next cycle: out_valid_o = 0, R' cleared, state IDLE.
  - in_valid_i is ignored in the flush cycle.
- Flush together with out_ready_i: the flush wins, and the beat counts as consumed.
- Reset during SPLIT: everything clears immediately.
- Back-to-back operation: with out_ready_i held at 1, independent bundles stream at 1 bundle per cycle.

Test Plan:
1. Reset with rst_i pulsed mid-stream (including in SPLIT) -> all outputs 0 on the same cycle; after release, in_ready_o = 1 and state is IDLE.
2. Independent bundle (LANES=2): lane0 0x00100293 (addi x5,x0,1) at PC 0x100, lane1 0x002083B3 (add x7,x1,x2) at PC 0x104, out_ready_i = 1 -> one beat a cycle later; lane_valid = 2'b11; both ctrl non-zero; no flags; the next bundle is accepted the same cycle.
3. RAW split: lane0 0x00100293, lane1 0x00528333 (add x6,x5,x5) -> beat 1 has lane_valid 2'b01; in_ready_o = 0; beat 2 has lane_valid 2'b10 with lane1 ctrl = ALUR; then in_ready_o = 1. Repeat with HAZARD_SPLIT = 0 -> single beat, lane_valid 2'b11.
4. Faults: lane0 0x00000000 at PC 0x200, lane1 0x00100293 at PC 0x1002 -> illegal = 2'b01, misalign = 2'b10, lane1 ctrl = 0. Separately, addi x0,x0,1 (0x00100013) -> ctrl = 0.
5. Backpressure: out_ready_i = 0 for 3 cycles after a valid beat -> all outputs stable and in_ready_o = 0; on release the beat is consumed and the next bundle accepted that cycle.
6. Flush: assert flush_i during SPLIT with in_valid_i = 1 -> next cycle out_valid_o = 0, remaining lane dropped, input not accepted; in the following cycle in_ready_o = 1.
